decoder_scan: RTL and testbench
===============================

DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 The module SHALL have the parameter EncodeWidth, default 4, giving the encoded index width.
REQ-002 The module SHALL have the parameter DecodeWidth, default 2**EncodeWidth, giving the decoded output width.
REQ-003 The module SHALL have the parameter DwellWidth, default 8, giving the dwell counter width.
REQ-004 The module SHALL use one clock and a synchronous, active-high reset.
REQ-005 The ports SHALL be as follows:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  request present.
- IN_READY  output  1  block can accept a request.
- MODE  input  2  00 one-hot, 01 thermometer, 10 scan, 11 reserved.
- IN  input  EncodeWidth  start index.
- LAST  input  EncodeWidth  scan end index; used only in scan mode.
- DWELL  input  DwellWidth  extra cycles per scan position; used only in scan mode.
- OUT  output  DecodeWidth  registered decoded vector.
- OUT_VALID  output  1  one-cycle pulse when OUT takes a new value.
- BUSY  output  1  scan in progress.
- DONE  output  1  one-cycle pulse at the end of a scan.

Function
REQ-006 The FSM SHALL have two states: IDLE and SCAN.
REQ-007 IN_READY SHALL equal 1 in IDLE and 0 in SCAN. A request is accepted on a cycle where IN_VALID=1 and IN_READY=1.
REQ-008 MODE, IN, LAST and DWELL SHALL be sampled only on the accept cycle; changes to them during SCAN SHALL have no effect.
REQ-009 One-hot mode: on accept, OUT SHALL become a vector with only bit IN set, and OUT_VALID SHALL pulse on the same edge.
- Latency: 1 cycle.
- The FSM stays in IDLE.
REQ-010 Thermometer mode: on accept, OUT[i] SHALL be 1 for all i<=IN and 0 otherwise; OUT_VALID SHALL pulse. IN=DecodeWidth-1 gives all ones.
REQ-011 Reserved mode 11 SHALL behave exactly as one-hot mode.
REQ-012 Scan mode, on accept:
- position P is loaded with IN;
- OUT becomes one-hot of IN;
- OUT_VALID pulses;
- the dwell counter is loaded with DWELL;
- the FSM enters SCAN.
REQ-013 In SCAN with dwell counter >0, the counter SHALL decrement and OUT SHALL hold.
REQ-014 In SCAN with counter =0 and P!=LAST, the block SHALL:
- set P to P+1 modulo DecodeWidth (wraps from DecodeWidth-1 to 0);
- update OUT to one-hot of the new P;
- pulse OUT_VALID;
- reload the counter with the sampled DWELL.
REQ-015 In SCAN with counter =0 and P=LAST, DONE SHALL pulse, the FSM SHALL return to IDLE, and OUT SHALL hold its final value.
REQ-016 Timing of a scan:
- every position, including the first and the last, is presented for exactly DWELL+1 cycles;
- total scan length is N*(DWELL+1) cycles, where N=((LAST-IN) mod DecodeWidth)+1.
REQ-017 Scan boundary cases:
- IN=LAST gives a single position;
- LAST<IN scans through the wrap-around point;
- DWELL=0 advances every cycle.
REQ-018 IN_READY SHALL be 1 on the cycle after DONE.
REQ-019 A request arriving during the DONE cycle SHALL NOT be accepted, because IN_READY=0 on that cycle.
REQ-020 BUSY SHALL be 1 exactly while the FSM is in SCAN.
REQ-021 OUT SHALL change only on accept or on a scan advance; between those events it SHALL hold its value.

Reset
REQ-022 When RST=1 at a clock edge, the block SHALL enter IDLE, including mid-scan, which abandons the scan without a DONE pulse.
REQ-023 Output values while in reset:
- OUT = '0;
- OUT_VALID = 0, BUSY = 0, DONE = 0;
- IN_READY = 1 on the first cycle after RST deasserts.
REQ-024 The position register and the dwell counter SHALL reset to 0.
REQ-025 RST SHALL take priority over a simultaneous accept.

Verification
REQ-026 The bench SHALL cover the following directed scenarios (EncodeWidth=4):
- One-hot: MODE=00, IN=5 accepted -> next cycle OUT=16'h0020, OUT_VALID=1 for 1 cycle, IN_READY stays 1.
- Thermometer: MODE=01, IN=3 -> OUT=16'h000F; IN=15 -> OUT=16'hFFFF; IN=0 -> OUT=16'h0001.
- Scan with dwell: MODE=10, IN=2, LAST=4, DWELL=1 -> OUT=0x0004 for 2 cycles, 0x0008 for 2 cycles, 0x0010 for 2 cycles; 3 OUT_VALID pulses; DONE pulses on the 6th SCAN-state cycle; BUSY high for 6 cycles.
- Scan with wrap: MODE=10, IN=14, LAST=1, DWELL=0 -> OUT sequence 0x4000, 0x8000, 0x0001, 0x0002, one per cycle, then DONE.
- Scan single position plus blocked request: IN=LAST=7, DWELL=0 -> OUT=0x0080 and DONE on the next cycle. A request held on IN_VALID during SCAN is not accepted until IN_READY=1.
- Reset mid-scan: assert RST during the 2nd position of a scan -> OUT='0, BUSY=0, no DONE pulse. A new one-hot request afterwards (IN=9) -> OUT=0x0200.

Source files
------------

// File: rtl/decoder_scan.sv
// decoder_scan: one-hot/thermometer index decoder with a dwell-timed scanning mode
module decoder_scan #(
    parameter int EncodeWidth = 4,
    parameter int DecodeWidth = 2 ** EncodeWidth,
    parameter int DwellWidth  = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [1:0]             MODE,
    input  logic [EncodeWidth-1:0] IN,
    input  logic [EncodeWidth-1:0] LAST,
    input  logic [DwellWidth-1:0]  DWELL,
    output logic [DecodeWidth-1:0] OUT,
    output logic                   OUT_VALID,
    output logic                   BUSY,
    output logic                   DONE
);
    typedef enum logic {IDLE, SCAN} state_t;
    state_t state_q, state_d;
    logic [EncodeWidth-1:0] p_q, p_d, last_q, last_d, p_next;
    logic [DwellWidth-1:0] cnt_q, cnt_d, dwell_q, dwell_d;
    logic [DecodeWidth-1:0] out_q, out_d, in_hot, p_hot;
    logic out_valid_q, out_valid_d, accept, at_end;
    assign in_hot = DecodeWidth'(1) << IN;
    assign p_next = (p_q == EncodeWidth'(DecodeWidth - 1)) ? '0 : p_q + 1'b1;
    assign p_hot = DecodeWidth'(1) << p_next;
    assign IN_READY = state_q == IDLE;
    assign BUSY = state_q == SCAN;
    assign accept = IN_VALID && IN_READY;
    assign at_end = p_q == last_q;
    // DONE is combinational so it lands on the final SCAN cycle and IN_READY rises right after
    assign DONE = BUSY && cnt_q == '0 && at_end;
    assign OUT = out_q;
    assign OUT_VALID = out_valid_q;
    always_comb begin
        state_d = state_q;
        p_d = p_q;
        last_d = last_q;
        cnt_d = cnt_q;
        dwell_d = dwell_q;
        out_d = out_q;
        out_valid_d = 1'b0;
        if (accept) begin
            out_valid_d = 1'b1;
            out_d = MODE == 2'b01 ? in_hot | (in_hot - 1'b1) : in_hot;
            if (MODE == 2'b10) begin
                state_d = SCAN;
                p_d = IN;
                last_d = LAST;
                cnt_d = DWELL;
                dwell_d = DWELL;
            end
        end else if (BUSY) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else if (!at_end) begin
                p_d = p_next;
                out_d = p_hot;
                out_valid_d = 1'b1;
                cnt_d = dwell_q;
            end else begin
                state_d = IDLE;
            end
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            p_q <= '0;
            last_q <= '0;
            cnt_q <= '0;
            dwell_q <= '0;
            out_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q <= p_d;
            last_q <= last_d;
            cnt_q <= cnt_d;
            dwell_q <= dwell_d;
            out_q <= out_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: scoreboard bench; a cycle-timed reference model predicts every OUT_VALID/DONE event
module tb_decoder_scan;
    logic CLK = 1'b0;
    logic RST, IN_VALID, IN_READY, OUT_VALID, BUSY, DONE;
    logic [1:0] MODE;
    logic [3:0] IN, LAST;
    logic [7:0] DWELL;
    logic [15:0] OUT;

    decoder_scan dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .MODE(MODE), .IN(IN), .LAST(LAST), .DWELL(DWELL),
        .OUT(OUT), .OUT_VALID(OUT_VALID), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {int t; logic [15:0] v;} ev_t;
    ev_t vq[$];
    int dq[$];
    int cyc = 0;
    int busy_start = 0;
    int busy_end = -1;
    int n_chk = 0;
    int n_pass = 0;
    logic [15:0] exp_out = '0;
    bit chk_en = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            if (vq.size() > 0 && vq[0].t == cyc) begin
                chk("out_valid", 32'(OUT_VALID), 1);
                chk("out_value", 32'(OUT), 32'(vq[0].v));
                exp_out = vq[0].v;
                void'(vq.pop_front());
            end else begin
                chk("out_valid", 32'(OUT_VALID), 0);
                chk("out_hold", 32'(OUT), 32'(exp_out));
            end
            if (dq.size() > 0 && dq[0] == cyc) begin
                chk("done", 32'(DONE), 1);
                void'(dq.pop_front());
            end else chk("done", 32'(DONE), 0);
            chk("busy", 32'(BUSY), 32'(cyc >= busy_start && cyc <= busy_end));
            chk("in_ready", 32'(IN_READY), 32'(!(cyc >= busy_start && cyc <= busy_end)));
        end
    end

    // Reference: scan visits N positions, each shown for d+1 cycles starting at the accept cycle t0
    task automatic model_accept(input logic [1:0] m, input int i, input int l, input int d, input int t0);
        ev_t e;
        int n;
        if (m == 2'b10) begin
            n = ((l - i + 16) % 16) + 1;
            for (int j = 0; j < n; j++) begin
                e.t = t0 + j * (d + 1);
                e.v = 16'(32'h1 << ((i + j) % 16));
                vq.push_back(e);
            end
            busy_start = t0;
            busy_end = t0 + n * (d + 1) - 1;
            dq.push_back(busy_end);
        end else begin
            e.t = t0;
            e.v = (m == 2'b01) ? 16'((32'h1 << (i + 1)) - 1) : 16'(32'h1 << i);
            vq.push_back(e);
        end
    endtask

    task automatic req(input logic [1:0] m, input int i, input int l, input int d);
        int w = 0;
        IN_VALID = 1'b1;
        MODE = m;
        IN = 4'(i);
        LAST = 4'(l);
        DWELL = 8'(d);
        while (cyc <= busy_end && w < 300) begin
            @(negedge CLK); #1;
            w++;
        end
        if (w >= 300) chk("accept_timeout", 32'(IN_READY), 1);
        model_accept(m, i, l, d, cyc + 1);
        @(negedge CLK); #1;
        IN_VALID = 1'b0;
        MODE = 2'($urandom);
        IN = 4'($urandom);
        LAST = 4'($urandom);
        DWELL = 8'($urandom);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        vq.delete();
        dq.delete();
        exp_out = '0;
        if (busy_end > cyc) busy_end = cyc;
        @(negedge CLK); #1;
        RST = 1'b0;
        IN_VALID = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((vq.size() > 0 || dq.size() > 0 || cyc <= busy_end) && w < 500) begin
            @(negedge CLK); #1;
            w++;
        end
        chk("drain_pending", 32'(vq.size() + dq.size()), 0);
    endtask

    initial begin
        RST = 1'b1;
        IN_VALID = 1'b0;
        MODE = '0;
        IN = '0;
        LAST = '0;
        DWELL = '0;
        @(posedge CLK);
        chk_en = 1;
        repeat (2) @(negedge CLK);
        #1;
        RST = 1'b0;
        req(2'b00, 5, 0, 0);
        @(negedge CLK); #1;
        req(2'b01, 3, 0, 0);
        req(2'b01, 15, 0, 0);
        req(2'b01, 0, 0, 0);
        req(2'b11, 12, 0, 0);
        req(2'b10, 2, 4, 1);
        drain();
        req(2'b10, 14, 1, 0);
        drain();
        req(2'b10, 7, 7, 0);
        req(2'b00, 11, 0, 0);
        drain();
        req(2'b10, 0, 5, 1);
        @(negedge CLK); #1;
        @(negedge CLK); #1;
        do_reset();
        req(2'b00, 9, 0, 0);
        IN_VALID = 1'b1;
        MODE = 2'b00;
        IN = 4'd3;
        do_reset();
        repeat (2) @(negedge CLK);
        #1;
        for (int k = 0; k < 40; k++)
            req(2'($urandom_range(0, 3)), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
        drain();
        repeat (2) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
